// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared encodings and helpers for the multiply/divide sequencer
// and the ALU instance it drives.
package muldiv_seq_pkg;

   localparam int unsigned MD_ITERS = 32;
   localparam int unsigned MD_W     = 32;

   // Operation select as presented on the op port.
   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   // ALU operation subset; the sequencer only ever selects ADDU/SUBU.
   typedef enum logic [2:0] {
      ALU_ADDU = 3'd0,
      ALU_SUBU = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_SLTU = 3'd5
   } alu_op_e;

   // Two's-complement negate of a word.
   function automatic logic [MD_W-1:0] neg32(input logic [MD_W-1:0] x);
      return MD_W'(~x + MD_W'(1));
   endfunction

   // Magnitude of a signed word; the most negative value maps to itself.
   function automatic logic [MD_W-1:0] abs32(input logic [MD_W-1:0] x);
      return x[MD_W-1] ? neg32(x) : x;
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between EX stage and the sequencer.
interface muldiv_seq_if
   import muldiv_seq_pkg::*;
;
   logic            start;
   logic [1:0]      op;
   logic [MD_W-1:0] a;
   logic [MD_W-1:0] b;
   logic            hi_we;
   logic            lo_we;
   logic [MD_W-1:0] wdata;
   logic            busy;
   logic            done;
   logic [MD_W-1:0] hi;
   logic [MD_W-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_seq_alu.sv
// muldiv_seq_alu: core ALU, used here purely as the iteration adder/subtractor.
module muldiv_seq_alu
   import muldiv_seq_pkg::*;
(
   input  logic [MD_W-1:0] a,
   input  logic [MD_W-1:0] b,
   input  alu_op_e         alu_op,
   output logic [MD_W-1:0] result_c
);

   // Combinational operation select.
   always_comb begin
      result_c = '0;
      unique case (alu_op)
         ALU_ADDU: result_c = MD_W'(a + b);
         ALU_SUBU: result_c = MD_W'(a - b);
         ALU_AND:  result_c = a & b;
         ALU_OR:   result_c = a | b;
         ALU_XOR:  result_c = a ^ b;
         ALU_SLTU: result_c = MD_W'(a < b);
         default:  result_c = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Shift-add multiply and restoring divide, one iteration per cycle through
// the shared ALU. Optional macro MULDIV_EARLY_OUT_EN lets a multiply finish
// as soon as the remaining multiplier bits are all zero.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int unsigned ITERS = MD_ITERS
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_seq_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(ITERS);
   localparam int unsigned ACC_W = 2 * MD_W;

   md_state_e state, state_nxt;

   md_op_e            op_q;
   logic              sign_a_q;
   logic              sign_b_q;
   logic              div_zero_q;
   logic [MD_W-1:0]   opnd_q;    // multiplicand or divisor
   logic [MD_W-1:0]   acc_hi_q;  // product high word or remainder
   logic [MD_W-1:0]   acc_lo_q;  // multiplier/product low word or quotient
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              done_q;
   logic [MD_W-1:0]   hi_q;
   logic [MD_W-1:0]   lo_q;

   logic              load, step, commit, busy_nxt, done_nxt;
   logic              is_div, last_iter;
   logic              req_div, req_signed, req_dz;
   logic [MD_W-1:0]   abs_a, abs_b;
   logic [MD_W:0]     rem_sh;
   alu_op_e           alu_op;
   logic [MD_W-1:0]   alu_a, alu_out;
   logic              carry, borrow;
   logic [MD_W-1:0]   mul_sum;
   logic              mul_c;
   logic              early;
   logic [ACC_W-1:0]  eo_acc;
   logic [ACC_W-1:0]  acc_neg;
   logic [MD_W-1:0]   fix_hi, fix_lo;

   assign is_div    = op_q[1];
   assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

   // Request decode: operand magnitudes for signed ops, divide-by-zero flag.
   always_comb begin
      req_div    = bus.op[1];
      req_signed = ~bus.op[0];
      abs_a      = req_signed ? abs32(bus.a) : bus.a;
      abs_b      = req_signed ? abs32(bus.b) : bus.b;
      req_dz     = req_div && (bus.b == '0);
   end

   // Iteration adder: ALU in ADDU for multiply, SUBU for divide; carry/borrow by compare.
   always_comb begin
      rem_sh  = {acc_hi_q, acc_lo_q[MD_W-1]};
      alu_op  = is_div ? ALU_SUBU : ALU_ADDU;
      alu_a   = is_div ? rem_sh[MD_W-1:0] : acc_hi_q;
      carry   = (alu_out < acc_hi_q);
      borrow  = (rem_sh < {1'b0, opnd_q});
      mul_sum = acc_lo_q[0] ? alu_out : acc_hi_q;
      mul_c   = acc_lo_q[0] & carry;
   end

   muldiv_seq_alu u_alu (
      .a        (alu_a),
      .b        (opnd_q),
      .alu_op   (alu_op),
      .result_c (alu_out)
   );

`ifdef MULDIV_EARLY_OUT_EN
   logic [CNT_W:0]   rem_cnt;
   logic [MD_W-1:0]  ones, rem_mask;

   // Early out: remaining multiplier bits are zero, so finish with one wide shift.
   always_comb begin
      ones     = '1;
      rem_cnt  = (CNT_W + 1)'(ITERS) - {1'b0, cnt_q};
      rem_mask = ~(ones << rem_cnt);
      early    = !is_div && ((acc_lo_q & rem_mask) == '0);
      eo_acc   = {acc_hi_q, acc_lo_q} >> rem_cnt;
   end
`else
   assign early  = 1'b0;
   assign eo_acc = '0;
`endif

   // Sign correction applied on the way into HI/LO.
   always_comb begin
      acc_neg = ACC_W'(~{acc_hi_q, acc_lo_q} + ACC_W'(1));
      fix_hi  = acc_hi_q;
      fix_lo  = acc_lo_q;
      if (!is_div) begin
         if (sign_a_q ^ sign_b_q) {fix_hi, fix_lo} = acc_neg;
      end else if (!div_zero_q) begin
         if (sign_a_q ^ sign_b_q) fix_lo = neg32(acc_lo_q);
         if (sign_a_q)            fix_hi = neg32(acc_hi_q);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MD_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         MD_IDLE: if (bus.start) state_nxt = MD_CALC;
         MD_CALC: if (early || last_iter) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_DONE;
         MD_DONE: state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   // Output and datapath-control decode.
   always_comb begin
      load     = (state == MD_IDLE) && bus.start;
      step     = (state == MD_CALC);
      commit   = (state == MD_FIX);
      busy_nxt = (state_nxt == MD_CALC) || (state_nxt == MD_FIX);
      done_nxt = (state_nxt == MD_DONE);
   end

   // Registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         done_q <= done_nxt;
      end
   end

   // Operand latch and per-cycle shift-add / restoring-divide iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= MD_MULT;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         div_zero_q <= 1'b0;
         opnd_q     <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         cnt_q      <= '0;
      end else if (load) begin
         op_q       <= md_op_e'(bus.op);
         sign_a_q   <= req_signed & bus.a[MD_W-1];
         sign_b_q   <= req_signed & bus.b[MD_W-1];
         div_zero_q <= req_dz;
         cnt_q      <= '0;
         acc_hi_q   <= '0;
         if (req_div) begin
            opnd_q   <= abs_b;
            acc_lo_q <= req_dz ? bus.a : abs_a;
         end else begin
            opnd_q   <= abs_a;
            acc_lo_q <= abs_b;
         end
      end else if (step) begin
         cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
         if (is_div) begin
            if (!borrow) begin
               acc_hi_q <= alu_out;
               acc_lo_q <= {acc_lo_q[MD_W-2:0], 1'b1};
            end else begin
               acc_hi_q <= rem_sh[MD_W-1:0];
               acc_lo_q <= {acc_lo_q[MD_W-2:0], 1'b0};
            end
         end else if (early) begin
            {acc_hi_q, acc_lo_q} <= eo_acc;
         end else begin
            acc_hi_q <= {mul_c, mul_sum[MD_W-1:1]};
            acc_lo_q <= {mul_sum[0], acc_lo_q[MD_W-1:1]};
         end
      end
   end

   // Architectural HI/LO: MTHI/MTLO in IDLE, result committed entering DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commit) begin
         hi_q <= fix_hi;
         lo_q <= fix_lo;
      end else if (state == MD_IDLE) begin
         if (bus.hi_we) hi_q <= bus.wdata;
         if (bus.lo_we) lo_q <= bus.wdata;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors plus a cycle-level reference model of the
// sequencer's visible behaviour (busy/done/hi/lo), compared every cycle.
module tb_muldiv_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_seq_if bus ();

   muldiv_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Architectural result as {hi, lo} using plain 64-bit arithmetic.
   function automatic logic [63:0] md_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (op)
         2'd0: return sa * sb;
         2'd1: return ua * ub;
         2'd2: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q = ua / ub;
            r = ua % ub;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Cycle (counting the start cycle as 0) on which done is expected.
   function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] ub;
      int k;
      if (op[1] == 1'b0) begin
         ub = (op == 2'd0 && b[31]) ? (~b + 32'd1) : b;
         if (ub == 32'h0) return 3;
         k = 0;
         for (int i = 0; i < 32; i++) if (ub[i]) k = i;
         return ((k == 31) ? 32 : k + 2) + 2;
      end
      return 34;
`else
      if (op == 2'd3 && b == 32'hDEAD_BEEF) return 34;
      return 34;
`endif
   endfunction

   // Reference model of visible state, advanced on each active clock edge.
   int          m_phase = 0;
   int          m_lat   = 34;
   logic [63:0] m_pend  = '0;
   logic [31:0] e_hi    = '0;
   logic [31:0] e_lo    = '0;
   logic        e_busy  = 1'b0;
   logic        e_done  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         e_hi    = '0;
         e_lo    = '0;
         e_busy  = 1'b0;
         e_done  = 1'b0;
      end else if (m_phase == 0) begin
         e_done = 1'b0;
         if (bus.hi_we) e_hi = bus.wdata;
         if (bus.lo_we) e_lo = bus.wdata;
         if (bus.start) begin
            m_pend  = md_result(bus.op, bus.a, bus.b);
            m_lat   = model_lat(bus.op, bus.b);
            m_phase = 1;
            e_busy  = 1'b1;
         end
      end else if (m_phase == m_lat) begin
         m_phase = 0;
         e_done  = 1'b0;
      end else begin
         m_phase++;
         if (m_phase == m_lat) begin
            e_hi   = m_pend[63:32];
            e_lo   = m_pend[31:0];
            e_busy = 1'b0;
            e_done = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cyc_busy", 32'(bus.busy), 32'(e_busy));
      chk("cyc_done", 32'(bus.done), 32'(e_done));
      chk("cyc_hi", bus.hi, e_hi);
      chk("cyc_lo", bus.lo, e_lo);
   end

   // Issue one op in an IDLE cycle; check done cycle and literal result.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input int lat);
      int got;
      got = -1;
      @(negedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk); #1;
      bus.start = 1'b0;
      for (int i = 2; i <= 60; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            got = i;
            break;
         end
      end
      chk({name, "_lat"}, 32'(got), 32'(lat));
      chk({name, "_hi"}, bus.hi, hi);
      chk({name, "_lo"}, bus.lo, lo);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ndone, dcyc;
      bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_hi", bus.hi, 32'h0);
      chk("rst_lo", bus.lo, 32'h0);
      #1 rst_n = 1'b1;

      run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
             model_lat(2'd1, 32'hFFFF_FFFF));
      run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
             model_lat(2'd0, 32'd7));
      run_op("mult_minmin", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,
             model_lat(2'd0, 32'h8000_0000));
      run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      run_op("divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 34);
      run_op("divu_zero", 2'd3, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 34);
      run_op("div_zero_neg", 2'd2, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 34);
      run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);

      // Busy interaction: start with MTLO in same cycle, then start+MTHI mid-op.
      ndone = 0; dcyc = -1;
      @(negedge clk); #1;
      bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd45; bus.b = 32'd6;
      bus.lo_we = 1'b1; bus.wdata = 32'h1234_5678;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ndone++;
            if (dcyc < 0) dcyc = i;
         end
         #1;
         bus.start = (i == 10); bus.hi_we = (i == 10); bus.lo_we = 1'b0;
         bus.op = (i == 10) ? 2'd0 : 2'd3;
         bus.wdata = (i == 10) ? 32'hAAAA_5555 : 32'h0;
      end
      chk("busy_ndone", 32'(ndone), 32'd1);
      chk("busy_dcyc", 32'(dcyc), 32'd34);
      chk("busy_hi", bus.hi, 32'd3);
      chk("busy_lo", bus.lo, 32'd7);
      bus.hi_we = 1'b1; bus.wdata = 32'hAAAA_5555;
      @(negedge clk);
      chk("mthi_idle", bus.hi, 32'hAAAA_5555);
      #1 bus.hi_we = 1'b0;

      // Reset mid-operation aborts without a done pulse.
      ndone = 0;
      @(negedge clk); #1;
      bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd7; bus.b = 32'd9;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
         if (i == 16) begin
            chk("rst_mid_busy", 32'(bus.busy), 32'h0);
            chk("rst_mid_hi", bus.hi, 32'h0);
            chk("rst_mid_lo", bus.lo, 32'h0);
         end
         #1;
         bus.start = 1'b0;
         if (i == 15) rst_n = 1'b0;
         if (i == 17) rst_n = 1'b1;
      end
      chk("rst_mid_ndone", 32'(ndone), 32'h0);
      run_op("post_rst", 2'd0, 32'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFC1,
             model_lat(2'd0, 32'hFFFF_FFF7));

`ifdef MULDIV_EARLY_OUT_EN
      begin
         int got;
         got = -1;
         @(negedge clk); #1;
         bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd5; bus.b = 32'd1;
         @(negedge clk); #1;
         bus.start = 1'b0;
         for (int i = 2; i <= 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
               got = i;
               break;
            end
         end
         chk("eo_lat_le4", 32'(got >= 2 && got <= 4), 32'h1);
         chk("eo_lo", bus.lo, 32'd5);
         chk("eo_hi", bus.hi, 32'd0);
         @(negedge clk);
      end
`endif

      repeat (4) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer for the MIPS150 core; implements MULT, MULTU, DIV, DIVU and owns the architectural HI/LO registers.
- Drives one existing ALU instance in ADDU/SUBU mode as its iteration adder: shift-add for multiply, restoring division for divide.
- Sits beside the EX stage. The pipeline stalls while busy is high, and MFHI/MFLO read hi/lo directly.

Parameters:
- ITERS, 32, iteration count; equals operand width. Other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  2  operation select: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- a  input  32  rs operand (multiplicand or dividend).
- b  input  32  rt operand (multiplier or divisor).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  32  MTHI/MTLO data.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; hi/lo hold the new result in the same cycle.
- hi  output  32  HI register (product high word, or remainder).
- lo  output  32  LO register (product low word, or quotient).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; all internal registers 0. Reset takes effect mid-operation: the operation is aborted and no done pulse is produced.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE→CALC on start. Latch op and sign flags. For signed ops, latch |a| and |b| as 32-bit unsigned values; |0x80000000| = 0x80000000. Iteration counter := 0.
  - CALC: one iteration per cycle.
    - Multiply: if the multiplier LSB is 1, acc_hi := acc_hi + multiplicand via ALU ADDU, keeping the carry as bit 32. Then shift {carry,acc_hi,acc_lo} right by 1.
    - Divide: shift {rem,quot} left by 1; trial = rem − divisor via ALU SUBU with a 33-bit borrow. If no borrow: rem := trial and quot LSB := 1; else quot LSB := 0.
    - CALC→FIX when counter = ITERS−1.
  - FIX: signed-result correction.
    - MULT: 64-bit negate when sign(a)^sign(b).
    - DIV: negate quotient when sign(a)^sign(b); negate remainder when sign(a).
    - Unsigned ops: no change. FIX→DONE.
  - DONE: write hi/lo, pulse done, then return to IDLE.
- Latency: with start accepted at cycle 0, done=1 at cycle ITERS+2 (34). The next start is accepted in the cycle after done.
- busy=1 in CALC and FIX only; busy=0 in DONE and IDLE.
- Divide by zero (b=0, DIV or DIVU): lo := 0xFFFFFFFF, hi := a unmodified, no sign fixup, normal 34-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the algorithm; no special case.
- start while not IDLE is ignored; no queueing.
- hi_we/lo_we:
  - In IDLE they update hi/lo in the next cycle.
  - If start and hi_we/lo_we occur in the same IDLE cycle, the write is applied and is later overwritten by the result.
  - Writes in CALC, FIX or DONE are dropped.
- hi/lo hold their last values throughout an operation; no partial results are visible.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in multiply CALC, when the remaining multiplier bits are all zero, shift acc right by the remaining count in one step and go to FIX. Latency is ≥3 cycles and data-dependent; the done handshake is unchanged. Divide is unaffected.
- Undefined: fixed 34-cycle latency for all ops.

Decomposition:
- Shared package / `include (alongside the existing ALUop/Opcode headers):
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op encodings.
  - MD_IDLE/MD_CALC/MD_FIX/MD_DONE state encodings.
  - MD_ITERS constant.
- Sub-module: reuse the existing ALU as the adder/subtractor instance; the carry/borrow bit comes from a parallel 33-bit compare in muldiv_seq.
- No other sub-module.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21).
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Busy interactions: start at cycle 0, then second start plus hi_we (wdata=0xAAAA5555) at cycle 10 → both ignored; exactly one done at cycle 34. hi_we in IDLE afterwards → hi=0xAAAA5555 next cycle.
- Reset and early-out:
  - rst_n low at cycle 15 → busy=0, hi=lo=0, no done pulse; a new start after reset completes normally.
  - With MULDIV_EARLY_OUT_EN: MULTU a=5, b=1 → done at ≤ cycle 4, lo=5.
